// File: rtl/regfile_scoreboard.sv
// General-purpose register file with write-through bypass, plus a per-register
// pending-write scoreboard that decode uses to stall on RAW hazards.
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int IDX_W    = $clog2(NREG),
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Wr_en,
  input  logic [IDX_W-1:0] Wr_idx,
  input  logic [XLEN-1:0]  Data_in,
  input  logic [IDX_W-1:0] R1_idx,
  input  logic [IDX_W-1:0] R2_idx,
  output logic [XLEN-1:0]  Reg_1,
  output logic [XLEN-1:0]  Reg_2,
  input  logic             Iss_en,
  input  logic [IDX_W-1:0] Iss_idx,
  input  logic             Flush,
  output logic             R1_busy,
  output logic             R2_busy,
  output logic [IDX_W:0]   Pend_cnt
);

  // Issue and writeback are plain strobes accepted every cycle; there is no
  // valid/ready pairing and no back-pressure anywhere in this block.

  logic [XLEN-1:0] gpr [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic [IDX_W:0]  cnt_next;
  logic            wr_allowed;
  logic            iss_allowed;

  assign wr_allowed  = Wr_en && !(ZERO_REG && (Wr_idx == '0));
  assign iss_allowed = Iss_en && !(ZERO_REG && (Iss_idx == '0));

  // Set is applied after clear so a new producer supersedes the retiring one.
  always_comb begin
    busy_next = busy;
    if (Flush) begin
      busy_next = '0;
    end else begin
      if (Wr_en)       busy_next[Wr_idx]  = 1'b0;
      if (iss_allowed) busy_next[Iss_idx] = 1'b1;
    end
  end

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_next = cnt_next + {{IDX_W{1'b0}}, busy_next[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      Pend_cnt <= '0;
    end else begin
      busy     <= busy_next;
      Pend_cnt <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else if (wr_allowed) begin
      gpr[Wr_idx] <= Data_in;
    end
  end

  // Zero-register forcing is applied last so it overrides the bypass.
  always_comb begin
    Reg_1 = gpr[R1_idx];
    if (Wr_en && (Wr_idx == R1_idx)) Reg_1 = Data_in;
    if (ZERO_REG && (R1_idx == '0))  Reg_1 = '0;

    Reg_2 = gpr[R2_idx];
    if (Wr_en && (Wr_idx == R2_idx)) Reg_2 = Data_in;
    if (ZERO_REG && (R2_idx == '0))  Reg_2 = '0;

    R1_busy = busy[R1_idx] && !(Wr_en && (Wr_idx == R1_idx))
              && !(ZERO_REG && (R1_idx == '0));
    R2_busy = busy[R2_idx] && !(Wr_en && (Wr_idx == R2_idx))
              && !(ZERO_REG && (R2_idx == '0));
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an array-based model.
module tb_regfile_scoreboard;

  localparam int XLEN     = 32;
  localparam int NREG     = 32;
  localparam int IDX_W    = $clog2(NREG);
  localparam bit ZERO_REG = 1'b1;
  localparam int N_RAND   = 3000;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [XLEN-1:0]  data_in;
  logic [IDX_W-1:0] r1_idx;
  logic [IDX_W-1:0] r2_idx;
  logic [XLEN-1:0]  reg_1;
  logic [XLEN-1:0]  reg_2;
  logic             iss_en;
  logic [IDX_W-1:0] iss_idx;
  logic             flush;
  logic             r1_busy;
  logic             r2_busy;
  logic [IDX_W:0]   pend_cnt;

  regfile_scoreboard #(
    .XLEN(XLEN), .NREG(NREG), .ZERO_REG(ZERO_REG)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .Wr_en(wr_en), .Wr_idx(wr_idx), .Data_in(data_in),
    .R1_idx(r1_idx), .R2_idx(r2_idx), .Reg_1(reg_1), .Reg_2(reg_2),
    .Iss_en(iss_en), .Iss_idx(iss_idx), .Flush(flush),
    .R1_busy(r1_busy), .R2_busy(r2_busy), .Pend_cnt(pend_cnt)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [XLEN-1:0] m_gpr  [NREG];
  bit              m_busy [NREG];
  logic [XLEN-1:0] exp_q[$];

  function automatic bit is_zero(input int idx);
    return ZERO_REG && (idx == 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        m_gpr[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wr_en && !is_zero(int'(wr_idx))) m_gpr[wr_idx] = data_in;
      if (flush) begin
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
      end else begin
        if (wr_en) m_busy[wr_idx] = 1'b0;
        if (iss_en && !is_zero(int'(iss_idx))) m_busy[iss_idx] = 1'b1;
      end
    end
  end

  function automatic logic [XLEN-1:0] model_read(input int idx);
    if (is_zero(idx)) return '0;
    if (wr_en && (int'(wr_idx) == idx)) return data_in;
    return m_gpr[idx];
  endfunction

  function automatic bit model_busy(input int idx);
    if (is_zero(idx)) return 1'b0;
    if (wr_en && (int'(wr_idx) == idx)) return 1'b0;
    return m_busy[idx];
  endfunction

  function automatic int model_pend();
    int c = 0;
    for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  // Compare process: outputs are meaningful every cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_q.push_back(model_read(int'(r1_idx)));
    exp_q.push_back(model_read(int'(r2_idx)));
    check("reg_1", 64'(reg_1), 64'(exp_q.pop_front()));
    check("reg_2", 64'(reg_2), 64'(exp_q.pop_front()));
    check("r1_busy", 64'(r1_busy), 64'(model_busy(int'(r1_idx))));
    check("r2_busy", 64'(r2_busy), 64'(model_busy(int'(r2_idx))));
    check("pend_cnt", 64'(pend_cnt), 64'(model_pend()));
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    wr_en = 1'b0; wr_idx = '0; data_in = '0;
    iss_en = 1'b0; iss_idx = '0; flush = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_write(input int idx, input logic [XLEN-1:0] d);
    wr_en = 1'b1; wr_idx = IDX_W'(idx); data_in = d;
  endtask

  task automatic do_issue(input int idx);
    iss_en = 1'b1; iss_idx = IDX_W'(idx);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    r1_idx = IDX_W'(5); r2_idx = IDX_W'(7);
    mid();
    check("reset_reg_1", 64'(reg_1), 64'h0);
    check("reset_pend", 64'(pend_cnt), 64'h0);
    check("reset_r1_busy", 64'(r1_busy), 64'h0);
    next_cycle();
    rst_n = 1'b1;

    // write with same-cycle bypass on both ports
    do_write(7, 32'h1234_5678);
    r1_idx = IDX_W'(7); r2_idx = IDX_W'(7);
    mid();
    check("bypass_reg_1", 64'(reg_1), 64'h1234_5678);
    check("bypass_reg_2", 64'(reg_2), 64'h1234_5678);
    next_cycle(); idle();
    mid();
    check("stored_reg_1", 64'(reg_1), 64'h1234_5678);
    check("stored_reg_2", 64'(reg_2), 64'h1234_5678);

    // register zero ignores writes and issue
    next_cycle();
    do_write(0, 32'hFFFF_FFFF); do_issue(0);
    r1_idx = '0;
    mid();
    check("zero_reg_1", 64'(reg_1), 64'h0);
    check("zero_busy", 64'(r1_busy), 64'h0);
    next_cycle(); idle();
    mid();
    check("zero_reg_1_after", 64'(reg_1), 64'h0);
    check("zero_pend", 64'(pend_cnt), 64'h0);

    // scoreboard: issue 3, write 3 three cycles later
    next_cycle();
    do_issue(3); r2_idx = IDX_W'(3);
    mid();
    check("sb_c1_busy", 64'(r2_busy), 64'h0);
    check("sb_c1_pend", 64'(pend_cnt), 64'h0);
    next_cycle(); idle();
    mid();
    check("sb_c2_busy", 64'(r2_busy), 64'h1);
    check("sb_c2_pend", 64'(pend_cnt), 64'h1);
    next_cycle();
    mid();
    check("sb_c3_busy", 64'(r2_busy), 64'h1);
    next_cycle();
    do_write(3, 32'h0000_00A5);
    mid();
    check("sb_c4_busy", 64'(r2_busy), 64'h0);
    check("sb_c4_reg_2", 64'(reg_2), 64'hA5);
    check("sb_c4_pend", 64'(pend_cnt), 64'h1);
    next_cycle(); idle();
    mid();
    check("sb_c5_pend", 64'(pend_cnt), 64'h0);
    check("sb_c5_busy", 64'(r2_busy), 64'h0);

    // collision: issue and writeback to 9 in the same cycle
    next_cycle();
    do_issue(9); r1_idx = IDX_W'(9);
    next_cycle(); idle();
    mid();
    check("col_pre_busy", 64'(r1_busy), 64'h1);
    next_cycle();
    do_issue(9); do_write(9, 32'h0000_0099);
    mid();
    check("col_bypass_busy", 64'(r1_busy), 64'h0);
    next_cycle(); idle();
    mid();
    check("col_busy_kept", 64'(r1_busy), 64'h1);
    check("col_reg_1", 64'(reg_1), 64'h99);
    check("col_pend", 64'(pend_cnt), 64'h1);

    // fill the scoreboard then flush with a competing issue
    for (int i = 1; i < NREG; i++) begin
      next_cycle(); idle(); do_issue(i);
    end
    next_cycle(); idle();
    mid();
    check("full_pend", 64'(pend_cnt), 64'd31);
    next_cycle();
    flush = 1'b1; do_issue(4);
    r1_idx = IDX_W'(4); r2_idx = IDX_W'(1);
    next_cycle(); idle();
    mid();
    check("flush_pend", 64'(pend_cnt), 64'h0);
    check("flush_r1_busy", 64'(r1_busy), 64'h0);
    check("flush_r2_busy", 64'(r2_busy), 64'h0);

    // asynchronous reset mid-run
    next_cycle();
    do_write(5, 32'hDEAD_BEEF); r1_idx = IDX_W'(5);
    next_cycle(); idle(); do_issue(6);
    mid();
    check("pre_rst_reg_1", 64'(reg_1), 64'hDEAD_BEEF);
    #1 rst_n = 1'b0;
    idle();
    #1;
    check("async_rst_reg_1", 64'(reg_1), 64'h0);
    check("async_rst_pend", 64'(pend_cnt), 64'h0);
    next_cycle();
    rst_n = 1'b1;

    // randomized traffic; compare process checks every cycle
    for (int n = 0; n < N_RAND; n++) begin
      idle();
      wr_en   = ($urandom_range(0, 9) < 4);
      wr_idx  = IDX_W'($urandom_range(0, NREG - 1));
      data_in = $urandom;
      iss_en  = ($urandom_range(0, 9) < 6);
      iss_idx = ($urandom_range(0, 7) == 0) ? wr_idx : IDX_W'($urandom_range(0, NREG - 1));
      flush   = ($urandom_range(0, 31) == 0);
      r1_idx  = ($urandom_range(0, 3) == 0) ? wr_idx : IDX_W'($urandom_range(0, NREG - 1));
      r2_idx  = ($urandom_range(0, 3) == 0) ? r1_idx : IDX_W'($urandom_range(0, NREG - 1));
      next_cycle();
    end
    idle();
    mid();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised general-purpose register file with an integrated busy-bit scoreboard for the pipelined core. It provides two combinational read ports and one write port, hardwires register 0 to zero, and bypasses same-cycle writes to the read ports. Per-register pending-write bits are set at issue, cleared at writeback and flushed on pipeline redirect. The decode stage uses the busy flags to stall on RAW hazards.

## Interface
Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of registers; power of two, 2..32.
- IDX_W, $clog2(NREG), index width (derived, not overridden).
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never marked busy.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Wr_en  in  1  writeback strobe.
- Wr_idx  in  IDX_W  writeback register index.
- Data_in  in  XLEN  writeback data.
- R1_idx  in  IDX_W  read port 1 index.
- R2_idx  in  IDX_W  read port 2 index.
- Reg_1  out  XLEN  read port 1 data (combinational).
- Reg_2  out  XLEN  read port 2 data (combinational).
- Iss_en  in  1  issue strobe; marks destination pending.
- Iss_idx  in  IDX_W  destination register of the issuing instruction.
- Flush  in  1  synchronous clear of all busy bits.
- R1_busy  out  1  R1_idx has a pending write not satisfied this cycle.
- R2_busy  out  1  R2_idx has a pending write not satisfied this cycle.
- Pend_cnt  out  IDX_W+1  number of registers currently marked busy.

## Operation
- Storage: NREG x XLEN array GPR, plus an NREG-bit busy vector.
- Write: on the rising edge with Wr_en=1, GPR[Wr_idx] <= Data_in. This is skipped when ZERO_REG=1 and Wr_idx=0.
- Read: Reg_n = 0 when ZERO_REG=1 and Rn_idx=0.
  - Otherwise Reg_n = Data_in when Wr_en=1 and Wr_idx=Rn_idx (write-through bypass).
  - Otherwise Reg_n = GPR[Rn_idx].
  - R1 and R2 may address the same register.
- Busy set: Iss_en=1 sets busy[Iss_idx] at the rising edge. This is suppressed for index 0 when ZERO_REG=1.
- Busy clear: Wr_en=1 clears busy[Wr_idx] at the rising edge.
- Simultaneous set and clear on the same index: set wins, because a new producer supersedes the old one. The data write still occurs.
- Flush=1: every busy bit is 0 after the edge; Iss_en that cycle is ignored. Wr_en data is still written.
- Rn_busy = busy[Rn_idx] & ~(Wr_en & Wr_idx==Rn_idx). A bypassed value is never reported busy. Rn_busy is 0 for index 0 when ZERO_REG=1.
- Pend_cnt: registered population count of the busy vector, updated in the same edge as the busy vector and always equal to it.
  - Max value is NREG, or NREG-1 when ZERO_REG=1.
  - Flush forces 0.

## Timing
- Reset (rst_n=0, asynchronous, no clock needed): all GPR = 0, busy = 0, Pend_cnt = 0.
  - Reg_1/Reg_2 are then 0 for any index with Wr_en=0; R1_busy = R2_busy = 0.
- Reset asserted mid-operation: state clears immediately; in-flight issue or writeback is discarded.
- Release of rst_n is synchronised by the system; the first active edge after release behaves normally.
- Read latency: 0 cycles (combinational from index, or from Data_in on bypass).
- Write latency: visible through GPR 1 cycle after the edge; visible through bypass in the same cycle.
- Busy latency: Iss_en in cycle N → Rn_busy high from cycle N+1 until the cycle of the matching Wr_en. In that Wr_en cycle Rn_busy=0 via bypass.
- No handshake back-pressure; Iss_en and Wr_en are accepted every cycle.

## Test plan
- Reset: drive rst_n=0 mid-run after writing GPR[5]=0xDEADBEEF → Reg_1 with R1_idx=5 reads 0 immediately; Pend_cnt=0.
- Write/read/bypass: Wr_en=1, Wr_idx=7, Data_in=0x12345678 with R1_idx=R2_idx=7 → both ports read 0x12345678 in the same cycle. With Wr_en=0 in the next cycle, still 0x12345678.
- Zero register: write 0xFFFFFFFF to index 0 and Iss_en with Iss_idx=0 → Reg_1=0, R1_busy=0, Pend_cnt unchanged.
- Scoreboard: Iss_idx=3 at cycle 1 → R2_busy=1 for R2_idx=3 from cycle 2; Wr_idx=3 at cycle 4 → R2_busy=0 in cycle 4; Pend_cnt goes 0→1→0.
- Collision and count: Iss_idx=9 and Wr_idx=9 in the same cycle with busy[9]=1 → busy[9] stays 1, GPR[9] updated, Pend_cnt unchanged.
- Flush: issue indices 1..31 (Pend_cnt=31), then Flush=1 together with Iss_en on 4 → Pend_cnt=0 and all busy low next cycle.
